// File: rtl/xgriscv_retire_monitor.sv
// xgriscv_retire_monitor
// Watches the writeback stage of xgriscv_pipeline. Every accepted retirement
// is pushed into a trace FIFO that is drained over a valid/ready port. The
// block counts cycles and retired instructions. It raises done once the run
// has ended (end-PC match or watchdog) and the FIFO has drained.
// Optional feature macro: XGRISCV_SELFLOOP_HALT_EN. When it is defined, a
// retired `jal x0,0` (0x0000006f) in RUN also ends the run, exactly like an
// end-PC match.
//
// Trace handshake: an entry moves from the monitor to the consumer at a
// rising clk edge where trace_valid && trace_ready are both high. trace_valid
// never depends on trace_ready. The head fields stay stable while trace_valid
// is high and no transfer happens. The head fields are meaningless while
// trace_valid is low.
module xgriscv_retire_monitor #(
    parameter int DEPTH = 8,
    parameter int WDOG  = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_instr,
    input  logic        retire_we,
    input  logic [4:0]  retire_rd,
    input  logic [31:0] retire_wdata,
    input  logic [31:0] end_pc,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [31:0] trace_wdata,
    output logic [4:0]  trace_rd,
    output logic        trace_we,
    output logic        done,
    output logic        timeout,
    output logic        overflow,
    output logic [31:0] cycle_count,
    output logic [31:0] instret,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + 32 + 32 + 5 + 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [31:0] WDOG_LAST = 32'(WDOG - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   wdog_cnt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic accept;
    logic push;
    logic end_hit;
    logic wdog_hit;
    logic counting;

    // Extra MSB on the pointers tells a full FIFO apart from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop    = !fifo_empty && trace_ready;
    // Retirements only count while the program is still executing.
    assign accept = retire_valid && ((state == S_IDLE) || (state == S_RUN));
    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    assign push   = accept && (!fifo_full || pop);

`ifdef XGRISCV_SELFLOOP_HALT_EN
    assign end_hit = (retire_pc == end_pc) || (retire_instr == 32'h0000_006f);
`else
    assign end_hit = (retire_pc == end_pc);
`endif

    assign wdog_hit = (state == S_RUN) && !retire_valid && (wdog_cnt == WDOG_LAST);
    assign counting = (state == S_RUN) || (state == S_DRAIN);

    assign entry_in = {retire_pc, retire_instr, retire_wdata, retire_rd, retire_we};
    assign head     = mem[rd_ptr[AW-1:0]];
    assign {trace_pc, trace_instr, trace_wdata, trace_rd, trace_we} = head;

    assign trace_valid = !fifo_empty;
    assign done        = (state == S_DONE);
    assign dbg_state   = state;

    // Run-control FSM together with the watchdog and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wdog_cnt <= 32'd0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wdog_cnt <= 32'd0;
                    if (retire_valid) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (retire_valid) begin
                        wdog_cnt <= 32'd0;
                        if (end_hit) begin
                            state <= S_DRAIN;
                        end
                    end else if (wdog_hit) begin
                        state   <= S_DRAIN;
                        timeout <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers; a pop and a push may happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; it needs no reset because the pointers mark which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry_in;
        end
    end

    // Saturating counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_count <= 32'd0;
            instret     <= 32'd0;
            overflow    <= 1'b0;
        end else begin
            if (counting && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (accept && (instret != 32'hFFFF_FFFF)) begin
                instret <= instret + 32'd1;
            end
            if (accept && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_retire_monitor.sv
// Bench for xgriscv_retire_monitor (DEPTH=8, WDOG=16).
// The reference model tracks the run phase, a queue of expected trace
// entries and the counters. The model is compared against the DUT at every
// falling edge. Directed scenarios add literal expectations on top of that.
module tb_xgriscv_retire_monitor;

    localparam int DEPTH = 8;
    localparam int WDOG  = 16;

    // Model run phases, numbered as the DUT reports them on dbg_state.
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_instr = '0;
    logic        retire_we = 1'b0;
    logic [4:0]  retire_rd = '0;
    logic [31:0] retire_wdata = '0;
    logic [31:0] end_pc = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic [31:0] trace_wdata;
    logic [4:0]  trace_rd;
    logic        trace_we;
    logic        done;
    logic        timeout;
    logic        overflow;
    logic [31:0] cycle_count;
    logic [31:0] instret;
    logic [1:0]  dbg_state;

    xgriscv_retire_monitor #(.DEPTH(DEPTH), .WDOG(WDOG)) dut (
        .clk(clk), .rstn(rstn),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .retire_we(retire_we), .retire_rd(retire_rd), .retire_wdata(retire_wdata),
        .end_pc(end_pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_wdata(trace_wdata),
        .trace_rd(trace_rd), .trace_we(trace_we),
        .done(done), .timeout(timeout), .overflow(overflow),
        .cycle_count(cycle_count), .instret(instret), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] got_pcs[$];
    int          m_phase;
    int          m_idle;
    logic        m_timeout;
    logic        m_overflow;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    bit          started = 1'b0;
    bit          s_valid;
    logic [31:0] s_pc;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_end(input logic [31:0] pc, input logic [31:0] instr);
`ifdef XGRISCV_SELFLOOP_HALT_EN
        return (pc == end_pc) || (instr == 32'h0000_006f);
`else
        return (pc == end_pc) && (instr === instr);
`endif
    endfunction

    // One clock edge of the reference behaviour, using inputs stable since the last falling edge.
    task automatic model_step();
        bit was_empty;
        bit acc;
        ent_t e;
        if (!rstn) begin
            exp_q.delete();
            m_phase = P_IDLE;
            m_idle = 0;
            m_timeout = 1'b0;
            m_overflow = 1'b0;
            m_cyc = 32'd0;
            m_ins = 32'd0;
            return;
        end
        if (s_valid && trace_ready) got_pcs.push_back(s_pc);
        was_empty = (exp_q.size() == 0);
        acc = retire_valid && (m_phase == P_IDLE || m_phase == P_RUN);
        if (!was_empty && trace_ready) void'(exp_q.pop_front());
        if (acc) begin
            if (m_ins != 32'hFFFF_FFFF) m_ins = m_ins + 1;
            if (exp_q.size() < DEPTH) begin
                e.pc = retire_pc; e.instr = retire_instr; e.wdata = retire_wdata;
                e.rd = retire_rd; e.we = retire_we;
                exp_q.push_back(e);
            end else begin
                m_overflow = 1'b1;
            end
        end
        if ((m_phase == P_RUN || m_phase == P_DRAIN) && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        case (m_phase)
            P_IDLE: if (retire_valid) m_phase = P_RUN;
            P_RUN: begin
                if (retire_valid) begin
                    m_idle = 0;
                    if (is_end(retire_pc, retire_instr)) m_phase = P_DRAIN;
                end else begin
                    m_idle++;
                    if (m_idle == WDOG) begin
                        m_phase = P_DRAIN;
                        m_timeout = 1'b1;
                    end
                end
            end
            P_DRAIN: if (was_empty) m_phase = P_DONE;
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            started = 1'b1;
        end
    end

    // Compare process: DUT against the model at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            s_valid = (trace_valid === 1'b1);
            s_pc = trace_pc;
            if (started) begin
                check("state", dbg_state, m_phase);
                check("trace_valid", trace_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    check("trace_pc", trace_pc, exp_q[0].pc);
                    check("trace_instr", trace_instr, exp_q[0].instr);
                    check("trace_wdata", trace_wdata, exp_q[0].wdata);
                    check("trace_rd", trace_rd, exp_q[0].rd);
                    check("trace_we", trace_we, exp_q[0].we);
                end
                check("done", done, m_phase == P_DONE);
                check("timeout", timeout, m_timeout);
                check("overflow", overflow, m_overflow);
                check("cycle_count", cycle_count, m_cyc);
                check("instret", instret, m_ins);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        #1;
        retire_valid = v;
        retire_pc = pc;
        retire_instr = instr;
        retire_wdata = pc ^ 32'hA5A5_0000;
        retire_rd = pc[6:2];
        retire_we = pc[2];
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
        drive(1'b1, pc, instr);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        retire_valid = 1'b0;
        trace_ready = 1'b0;
        @(negedge clk);
        #1;
        rstn = 1'b1;
        got_pcs.delete();
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && done !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        check({name, " done"}, done, 1'b1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        do_reset();
        check("rst trace_valid", trace_valid, 0);
        check("rst done", done, 0);
        check("rst timeout", timeout, 0);
        check("rst overflow", overflow, 0);
        check("rst cycle_count", cycle_count, 0);
        check("rst instret", instret, 0);

        // Five retirements ending at end_pc with the consumer always ready.
        end_pc = 32'h10;
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) retire(32'(i * 4), 32'h0000_0013);
        idle();
        wait_done(20, "t1");
        check("t1 instret", instret, 5);
        check("t1 cycle_count", cycle_count, 6);
        check("t1 timeout", timeout, 0);
        check("t1 overflow", overflow, 0);
        check("t1 n_entries", got_pcs.size(), 5);
        for (int i = 0; i < 5 && i < got_pcs.size(); i++) check("t1 entry pc", got_pcs[i], 32'(i * 4));

        // Ten retirements into a blocked FIFO: two get dropped.
        do_reset();
        end_pc = 32'h1000;
        for (int i = 0; i < 10; i++) retire(32'(i * 4), 32'h0000_0033);
        idle();
        check("t2 instret", instret, 10);
        check("t2 overflow", overflow, 1);
        trace_ready = 1'b1;
        wait_done(60, "t2");
        check("t2 n_entries", got_pcs.size(), 8);
        for (int i = 0; i < 8 && i < got_pcs.size(); i++) check("t2 entry pc", got_pcs[i], 32'(i * 4));
        check("t2 timeout", timeout, 1);

        // A full FIFO takes a push when a pop happens in the same cycle.
        do_reset();
        end_pc = 32'h1000;
        for (int i = 0; i < 8; i++) retire(32'h100 + 32'(i * 4), 32'h0000_0013);
        retire(32'h120, 32'h0000_0013);
        trace_ready = 1'b1;
        idle();
        trace_ready = 1'b0;
        check("t3 overflow", overflow, 0);
        check("t3 head pc", trace_pc, 32'h104);
        check("t3 instret", instret, 9);
        trace_ready = 1'b1;
        wait_done(60, "t3");
        check("t3 n_entries", got_pcs.size(), 9);
        if (got_pcs.size() == 9) begin
            check("t3 first pc", got_pcs[0], 32'h100);
            check("t3 last pc", got_pcs[8], 32'h120);
        end
        check("t3 overflow end", overflow, 0);

        // A single retirement, then silence until the watchdog fires.
        do_reset();
        end_pc = 32'h1000;
        trace_ready = 1'b1;
        retire(32'h0, 32'h0000_0013);
        idle();
        wait_done(40, "t4");
        check("t4 timeout", timeout, 1);
        check("t4 cycle_count>=17", cycle_count >= 32'd17, 1);
        check("t4 instret", instret, 1);

        // A self-loop instruction at 0x8 with end_pc far away.
        do_reset();
        end_pc = 32'h78;
        trace_ready = 1'b1;
        retire(32'h0, 32'h0000_0013);
        retire(32'h4, 32'h0000_0013);
        retire(32'h8, 32'h0000_006f);
        idle();
`ifdef XGRISCV_SELFLOOP_HALT_EN
        check("t5 state after jal", dbg_state, P_DRAIN);
        wait_done(40, "t5");
        check("t5 timeout", timeout, 0);
`else
        check("t5 state after jal", dbg_state, P_RUN);
        wait_done(40, "t5");
        check("t5 timeout", timeout, 1);
`endif
        check("t5 instret", instret, 3);

        // Reset mid-run with three entries queued, then a clean restart.
        do_reset();
        end_pc = 32'h1000;
        for (int i = 0; i < 3; i++) retire(32'(i * 4), 32'h0000_0013);
        idle();
        check("t6 pre trace_valid", trace_valid, 1);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check("t6 trace_valid", trace_valid, 0);
        check("t6 cycle_count", cycle_count, 0);
        check("t6 instret", instret, 0);
        check("t6 state", dbg_state, P_IDLE);
        check("t6 overflow", overflow, 0);
        rstn = 1'b1;
        got_pcs.delete();
        end_pc = 32'h10;
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) retire(32'(i * 4), 32'h0000_0013);
        idle();
        wait_done(20, "t6");
        check("t6 instret", instret, 5);
        check("t6 n_entries", got_pcs.size(), 5);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, got %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "bench time limit");
    end

endmodule
